// File: rtl/program_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package program_loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_BASE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_START,
    S_DONE,
    S_ERR
  } loader_state_t;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts_bytes(input loader_state_t s);
    return s inside {S_BASE, S_COUNT, S_DATA, S_CSUM};
  endfunction

endpackage

// File: rtl/program_loader_byte_packer.sv
// Byte-stream handshake and hi/lo pairing; presents a completed word in the cycle its lo byte is accepted.
module program_loader_byte_packer
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              en_i,
  output logic              fire_c,
  output logic [WORD_W-1:0] word_c,
  output logic              word_valid_c
);

  logic              phase_lo_q, phase_lo_d;
  logic [BYTE_W-1:0] hi_q, hi_d;

  always_comb begin
    fire_c       = in_valid_i & en_i;
    word_c       = {hi_q, in_data_i};
    word_valid_c = fire_c & phase_lo_q;
    phase_lo_d   = phase_lo_q;
    hi_d         = hi_q;
    if (fire_c) begin
      phase_lo_d = ~phase_lo_q;
      if (!phase_lo_q) hi_d = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_lo_q <= 1'b0;
      hi_q       <= '0;
    end else begin
      phase_lo_q <= phase_lo_d;
      hi_q       <= hi_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives BASE/COUNT/payload/CSUM over a byte stream, writes the payload to RAM, starts the core.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] cpu_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     remaining_q, remaining_d;
  logic [WORD_W-1:0]     sum_q, sum_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  in_ready_q, in_ready_d;
  logic                  write_q, write_d;
  logic                  oe_q, oe_d;
  logic                  start_q, start_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  fire_c;
  logic [WORD_W-1:0]     word_c;
  logic                  word_valid_c;

  program_loader_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .en_i         (in_ready_q),
    .fire_c       (fire_c),
    .word_c       (word_c),
    .word_valid_c (word_valid_c)
  );

  // Next state plus next values of every registered output (decoded from state_d).
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    sum_d       = sum_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      S_BASE: if (word_valid_c) begin
        base_d  = ADDR_WIDTH'(word_c);
        addr_d  = ADDR_WIDTH'(word_c);
        state_d = S_COUNT;
      end
      S_COUNT: if (word_valid_c) begin
        remaining_d = word_c;
        sum_d       = '0;
        state_d     = (word_c == '0) ? S_CSUM : S_DATA;
      end
      S_DATA: if (word_valid_c) begin
        wdata_d = word_c;
        sum_d   = sum_q + word_c;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_d      = addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - WORD_W'(1);
        state_d     = (remaining_q == WORD_W'(1)) ? S_CSUM : S_DATA;
      end
      S_CSUM: if (word_valid_c) begin
        state_d = (word_c == sum_q) ? S_START : S_ERR;
      end
      S_START: state_d = S_DONE;
      default: state_d = state_q;
    endcase

    in_ready_d = accepts_bytes(state_d);
    write_d    = (state_d == S_WRITE);
    oe_d       = (state_d != S_WRITE);
    start_d    = (state_d == S_START);
    pc_d       = (state_d == S_START) ? base_d : pc_q;
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    busy_d     = (busy_q | fire_c) & ~(done_d | err_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BASE;
      base_q      <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b1;
      write_q     <= 1'b0;
      oe_q        <= 1'b1;
      start_q     <= 1'b0;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      sum_q       <= sum_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      write_q     <= write_d;
      oe_q        <= oe_d;
      start_q     <= start_d;
      pc_q        <= pc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_addr  = addr_q;
  assign mem_cs    = write_q;
  assign mem_we    = write_q;
  assign mem_oe    = oe_q;
  assign cpu_start = start_q;
  assign cpu_pc    = pc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  // RAM bus is released whenever the loader is not writing.
  assign mem_data = oe_q ? 'z : DATA_WIDTH'(wdata_q);

endmodule
